instr_fetch_unit: RTL and testbench

- Reader side of the 8-bit CPU's instruction memory port. It drives the byte address and samples the combinational read data.
- Assembles 1-byte (ADD/SUB) and 2-byte (LOAD/STORE: opcode + address operand) instructions.
- Presents each complete instruction to the decoder over a valid/ready handshake.
- Owns the PC, accepts branch redirects, and stops fetching after HLT.

---
 rtl/instr_fetch_unit.sv | 149 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Reader side of the 8-bit CPU's instruction memory port. Owns the PC, reads
// opcode (and, for LOAD/STORE, an address operand) bytes from a combinational
// instruction memory, and presents each complete instruction to the decoder
// as one bundle. Branch redirects discard any partial or held bundle. After an
// HLT bundle is accepted, fetching stops until reset.
//
// Handshake: a bundle transfers on a clk edge where instr_valid = 1 and
// instr_ready = 1 and branch_en = 0. While instr_valid = 1 and no transfer
// happens, every instr_* output holds its value. instr_valid never depends
// combinationally on instr_ready.
//
// Ports:
//   clk            in   1  system clock, rising edge
//   rst_n          in   1  synchronous active-low reset
//   imem_addr      out  8  instruction memory byte address (= pc)
//   imem_data      in   8  instruction memory read data (combinational)
//   instr_valid    out  1  bundle valid
//   instr_ready    in   1  decoder accepts the bundle
//   instr_opcode   out  8  first instruction byte
//   instr_operand  out  8  second byte, 8'h00 for 1-byte instructions
//   instr_two_byte out  1  bundle carries an operand
//   instr_pc       out  8  address of the opcode byte
//   branch_en      in   1  redirect request
//   branch_target  in   8  new PC when branch_en = 1
//   halted         out  1  HLT accepted; fetch stopped
//
// The FSM state is the internal signal "state" (type state_t) for checkers.
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [7:0] RESET_PC   = 8'h00,
    parameter logic [3:0] HLT_NIBBLE = 4'hF
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] imem_addr,
    input  logic [7:0] imem_data,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic [7:0] instr_opcode,
    output logic [7:0] instr_operand,
    output logic       instr_two_byte,
    output logic [7:0] instr_pc,
    input  logic       branch_en,
    input  logic [7:0] branch_target,
    output logic       halted
);

    typedef enum logic [1:0] {
        FETCH_OP  = 2'd0,
        FETCH_OPR = 2'd1,
        HOLD      = 2'd2,
        HALTED    = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] pc;
    logic       two_byte;
    logic       redirect;
    logic       is_hlt;

    assign imem_addr = pc;

    // LOAD (1001xxxx) and STORE (1101xxxx) carry an address operand.
    assign two_byte = imem_data[7] & ~imem_data[5];

    // A redirect wins over everything except reset, including a same-cycle
    // handshake in HOLD; HALTED ignores it.
    assign redirect = branch_en && (state != HALTED);

    assign is_hlt = (instr_opcode[7:4] == HLT_NIBBLE);

    always_comb begin
        state_next = state;
        if (redirect) begin
            state_next = FETCH_OP;
        end else begin
            case (state)
                FETCH_OP:  state_next = two_byte ? FETCH_OPR : HOLD;
                FETCH_OPR: state_next = HOLD;
                HOLD: begin
                    if (instr_ready) begin
                        state_next = is_hlt ? HALTED : FETCH_OP;
                    end
                end
                HALTED:    state_next = HALTED;
                default:   state_next = FETCH_OP;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FETCH_OP;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers follow the same decisions as the next-state logic.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc             <= RESET_PC;
            instr_valid    <= 1'b0;
            instr_opcode   <= 8'h00;
            instr_operand  <= 8'h00;
            instr_two_byte <= 1'b0;
            instr_pc       <= 8'h00;
            halted         <= 1'b0;
        end else if (redirect) begin
            pc          <= branch_target;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                FETCH_OP: begin
                    instr_opcode   <= imem_data;
                    instr_pc       <= pc;
                    instr_two_byte <= two_byte;
                    pc             <= pc + 8'd1;
                    if (!two_byte) begin
                        instr_operand <= 8'h00;
                        instr_valid   <= 1'b1;
                    end
                end
                FETCH_OPR: begin
                    // pc wraps naturally: an opcode at FF reads its operand at 00.
                    instr_operand <= imem_data;
                    pc            <= pc + 8'd1;
                    instr_valid   <= 1'b1;
                end
                HOLD: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        if (is_hlt) begin
                            halted <= 1'b1;
                        end
                    end
                end
                default: begin
                    // HALTED: everything frozen until reset.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (RESET_PC = 00) ----------------
  logic       rst_n = 1'b0;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic [7:0] instr_opcode;
  logic [7:0] instr_operand;
  logic       instr_two_byte;
  logic [7:0] instr_pc;
  logic       branch_en = 1'b0;
  logic [7:0] branch_target = 8'h00;
  logic       halted;
  logic [7:0] mem [256];

  assign imem_data = mem[imem_addr];

  instr_fetch_unit #(.RESET_PC(8'h00), .HLT_NIBBLE(4'hF)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_operand(instr_operand),
    .instr_two_byte(instr_two_byte), .instr_pc(instr_pc),
    .branch_en(branch_en), .branch_target(branch_target), .halted(halted)
  );

  // ---------------- second DUT (RESET_PC = FF) ----------------
  logic       rst2_n = 1'b0;
  logic [7:0] addr2;
  logic [7:0] data2;
  logic       valid2;
  logic       ready2 = 1'b0;
  logic [7:0] op2;
  logic [7:0] opr2;
  logic       two2;
  logic [7:0] ipc2;
  logic       br2 = 1'b0;
  logic [7:0] tgt2 = 8'h00;
  logic       halted2;
  logic [7:0] mem2 [256];

  assign data2 = mem2[addr2];

  instr_fetch_unit #(.RESET_PC(8'hFF), .HLT_NIBBLE(4'hF)) dut_ff (
    .clk(clk), .rst_n(rst2_n), .imem_addr(addr2), .imem_data(data2),
    .instr_valid(valid2), .instr_ready(ready2),
    .instr_opcode(op2), .instr_operand(opr2),
    .instr_two_byte(two2), .instr_pc(ipc2),
    .branch_en(br2), .branch_target(tgt2), .halted(halted2)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int total_cnt = 0;
  int pass_cnt  = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       r;      // rst_n
    logic       rd;     // instr_ready
    logic       b;      // branch_en
    logic [7:0] t;      // branch_target
    logic       vl;     // expected instr_valid
    logic       ck;     // compare bundle fields
    logic [7:0] op;
    logic [7:0] opr;
    logic       tw;
    logic [7:0] ip;
    logic [7:0] a;      // expected imem_addr
    logic       h;      // expected halted
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic rd, input logic b, input logic [7:0] t,
                     input logic vl, input logic ck, input logic [7:0] op,
                     input logic [7:0] opr, input logic tw, input logic [7:0] ip,
                     input logic [7:0] a, input logic h);
    vec_t v;
    v.r = r; v.rd = rd; v.b = b; v.t = t; v.vl = vl; v.ck = ck;
    v.op = op; v.opr = opr; v.tw = tw; v.ip = ip; v.a = a; v.h = h;
    vecs.push_back(v);
  endtask

  // ---------------- reference model (instruction level) ----------------
  logic [7:0] model_pc;
  logic       model_halted;

  function automatic logic is_two(input logic [7:0] op);
    return op[7] && !op[5];
  endfunction

  initial begin
    logic [7:0] e_op, e_opr;
    logic       e_two;
    logic       r, rd, b;
    logic [7:0] t;
    int         halt_cnt;
    int         accepts;

    foreach (mem[i]) mem[i] = 8'h00;
    foreach (mem2[i]) mem2[i] = 8'h00;
    mem[8'h00] = 8'h90; mem[8'h01] = 8'h20; mem[8'h02] = 8'h11; mem[8'h03] = 8'hF0;
    mem[8'h30] = 8'h11; mem[8'h31] = 8'hF0;
    mem2[8'hFF] = 8'hD4; mem2[8'h00] = 8'h41;

    // ---- RESET_PC = FF wrap sequence ----
    @(posedge clk); #1;
    chk("ff_reset_addr", addr2, 8'hFF);
    rst2_n = 1'b1; ready2 = 1'b0;
    @(posedge clk); #1;
    chk("ff_opr_addr", addr2, 8'h00);
    chk("ff_opr_valid", {7'd0, valid2}, 8'h00);
    @(posedge clk); #1;
    chk("ff_valid", {7'd0, valid2}, 8'h01);
    chk("ff_opcode", op2, 8'hD4);
    chk("ff_operand", opr2, 8'h41);
    chk("ff_two_byte", {7'd0, two2}, 8'h01);
    chk("ff_pc", ipc2, 8'hFF);
    chk("ff_next_addr", addr2, 8'h01);

    // ---- directed table on main DUT ----
    //   r  rd b  t      vl ck op     opr    tw ip     addr   h
    add(0, 1, 0, 8'h00, 0, 1, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
    add(1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h01, 0);
    add(1, 1, 0, 8'h00, 1, 1, 8'h90, 8'h20, 1, 8'h00, 8'h02, 0);
    add(1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h02, 0);
    add(1, 1, 0, 8'h00, 1, 1, 8'h11, 8'h00, 0, 8'h02, 8'h03, 0);
    add(1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h03, 0);
    add(1, 1, 0, 8'h00, 1, 1, 8'hF0, 8'h00, 0, 8'h03, 8'h04, 0);
    add(1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h04, 1);
    add(1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h04, 1);
    add(1, 1, 1, 8'h30, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h04, 1);
    // reset while halted, then ready-low stall
    add(0, 0, 0, 8'h00, 0, 1, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
    add(1, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h01, 0);
    add(1, 0, 0, 8'h00, 1, 1, 8'h90, 8'h20, 1, 8'h00, 8'h02, 0);
    for (int i = 0; i < 5; i++)
      add(1, 0, 0, 8'h00, 1, 1, 8'h90, 8'h20, 1, 8'h00, 8'h02, 0);
    add(1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h02, 0);
    add(1, 1, 0, 8'h00, 1, 1, 8'h11, 8'h00, 0, 8'h02, 8'h03, 0);
    // branch during FETCH_OPR of 90 at 00
    add(0, 1, 0, 8'h00, 0, 1, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
    add(1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h01, 0);
    add(1, 1, 1, 8'h30, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h30, 0);
    add(1, 1, 0, 8'h00, 1, 1, 8'h11, 8'h00, 0, 8'h30, 8'h31, 0);
    add(1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h31, 0);
    add(1, 1, 0, 8'h00, 1, 1, 8'hF0, 8'h00, 0, 8'h31, 8'h32, 0);
    // branch together with ready while holding HLT: no halt
    add(1, 1, 1, 8'h02, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h02, 0);
    add(1, 1, 0, 8'h00, 1, 1, 8'h11, 8'h00, 0, 8'h02, 8'h03, 0);
    // reset mid-FETCH_OPR
    add(0, 0, 0, 8'h00, 0, 1, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
    add(1, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h01, 0);
    add(0, 0, 0, 8'h00, 0, 1, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);
    add(1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h01, 0);
    add(1, 1, 0, 8'h00, 1, 1, 8'h90, 8'h20, 1, 8'h00, 8'h02, 0);

    foreach (vecs[i]) begin
      rst_n = vecs[i].r; instr_ready = vecs[i].rd;
      branch_en = vecs[i].b; branch_target = vecs[i].t;
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), {7'd0, instr_valid}, {7'd0, vecs[i].vl});
      chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].a);
      chk($sformatf("v%0d_halted", i), {7'd0, halted}, {7'd0, vecs[i].h});
      if (vecs[i].ck) begin
        chk($sformatf("v%0d_opcode", i), instr_opcode, vecs[i].op);
        chk($sformatf("v%0d_operand", i), instr_operand, vecs[i].opr);
        chk($sformatf("v%0d_two_byte", i), {7'd0, instr_two_byte}, {7'd0, vecs[i].tw});
        chk($sformatf("v%0d_pc", i), instr_pc, vecs[i].ip);
      end
    end

    // ---- randomized run against the instruction-level model ----
    model_pc = 8'h00; model_halted = 1'b0; halt_cnt = 0; accepts = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      r  = !(cyc == 0 || $urandom_range(0, 199) == 0 || halt_cnt >= 4);
      rd = ($urandom_range(0, 9) < 7);
      b  = ($urandom_range(0, 24) == 0);
      t  = 8'($urandom_range(0, 255));
      if (!r) foreach (mem[i]) mem[i] = 8'($urandom_range(0, 255));
      rst_n = r; instr_ready = rd; branch_en = b; branch_target = t;

      // Any valid bundle must be the instruction at the model's PC.
      if (r && instr_valid) begin
        e_op  = mem[model_pc];
        e_two = is_two(e_op);
        e_opr = e_two ? mem[model_pc + 8'd1] : 8'h00;
        chk("rnd_opcode", instr_opcode, e_op);
        chk("rnd_operand", instr_operand, e_opr);
        chk("rnd_two_byte", {7'd0, instr_two_byte}, {7'd0, e_two});
        chk("rnd_pc", instr_pc, model_pc);
      end

      if (!r) begin
        model_pc = 8'h00; model_halted = 1'b0;
      end else if (model_halted) begin
        // frozen
      end else if (b) begin
        model_pc = t;
      end else if (instr_valid && rd) begin
        accepts++;
        if (mem[model_pc][7:4] == 4'hF) model_halted = 1'b1;
        model_pc = model_pc + (is_two(mem[model_pc]) ? 8'd2 : 8'd1);
      end

      @(posedge clk); #1;
      chk("rnd_halted", {7'd0, halted}, {7'd0, model_halted});
      if (model_halted) begin
        chk("rnd_halt_valid", {7'd0, instr_valid}, 8'h00);
        chk("rnd_halt_addr", imem_addr, model_pc);
      end
      halt_cnt = model_halted ? halt_cnt + 1 : 0;
    end
    chk("rnd_progress", {7'd0, accepts >= 500}, 8'h01);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
